// File: rtl/serial_pkg.sv
// Shared types for the bit-serial operand stream (transmitter and sum deserializer).
// The length typedef matches the default operand width of 8 bits.
package serial_pkg;

   typedef enum logic [0:0] {
      TX_IDLE  = 1'b0,
      TX_SHIFT = 1'b1
   } tx_state_t;

   localparam int SER_WIDTH = 8;
   localparam int SER_LENW  = $clog2(SER_WIDTH);

   typedef logic [SER_LENW-1:0] ser_len_t;

endpackage

// File: rtl/serial_operand_tx.sv
// Bit-serial transmitter: takes an operand pair through valid/ready and streams it LSB first
// as (vld, a, b, last), paced by out_en, with back-to-back hand-over on the last bit.
module serial_operand_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LENW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [LENW-1:0]  in_len,
   input  logic             out_en,
   output logic             vld,
   output logic             a,
   output logic             b,
   output logic             last,
   output logic             busy
);

   localparam logic [LENW-1:0] CNT_ONE = LENW'(1);

   tx_state_t        state_r, state_nxt_s;
   logic [WIDTH-1:0] sh_a_r, sh_a_nxt_s;
   logic [WIDTH-1:0] sh_b_r, sh_b_nxt_s;
   logic [LENW-1:0]  cnt_r, cnt_nxt_s;
   logic             busy_r;
   logic             vld_s;
   logic             last_s;
   logic             ready_s;
   logic             accept_s;

   // Stream outputs and handshake; reset gates them so an abort is visible at once
   always_comb begin
      vld_s    = 1'b0;
      last_s   = 1'b0;
      ready_s  = 1'b0;
      if (rst) begin
         vld_s   = 1'b0;
         last_s  = 1'b0;
         ready_s = 1'b0;
      end else begin
         vld_s   = (state_r == TX_SHIFT) && out_en;
         last_s  = vld_s && (cnt_r == '0);
         ready_s = (state_r == TX_IDLE) || last_s;
      end
      accept_s = in_valid && ready_s;
   end

   assign vld      = vld_s;
   assign a        = vld_s & sh_a_r[0];
   assign b        = vld_s & sh_b_r[0];
   assign last     = last_s;
   assign in_ready = ready_s;
   assign busy     = busy_r;

   // Next-state: load on acceptance, shift and count down on each emitted pair
   always_comb begin
      state_nxt_s = state_r;
      sh_a_nxt_s  = sh_a_r;
      sh_b_nxt_s  = sh_b_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         TX_IDLE: begin
            if (accept_s) begin
               sh_a_nxt_s  = in_a;
               sh_b_nxt_s  = in_b;
               cnt_nxt_s   = in_len;
               state_nxt_s = TX_SHIFT;
            end else begin
               state_nxt_s = TX_IDLE;
            end
         end
         TX_SHIFT: begin
            if (accept_s) begin
               sh_a_nxt_s  = in_a;
               sh_b_nxt_s  = in_b;
               cnt_nxt_s   = in_len;
               state_nxt_s = TX_SHIFT;
            end else if (last_s) begin
               sh_a_nxt_s  = '0;
               sh_b_nxt_s  = '0;
               state_nxt_s = TX_IDLE;
            end else if (vld_s) begin
               sh_a_nxt_s = {1'b0, sh_a_r[WIDTH-1:1]};
               sh_b_nxt_s = {1'b0, sh_b_r[WIDTH-1:1]};
               cnt_nxt_s  = cnt_r - CNT_ONE;
            end else begin
               state_nxt_s = TX_SHIFT;
            end
         end
         default: begin
            state_nxt_s = TX_IDLE;
         end
      endcase
   end

   // State, shifters, counter and busy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= TX_IDLE;
         sh_a_r  <= '0;
         sh_b_r  <= '0;
         cnt_r   <= '0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         sh_a_r  <= sh_a_nxt_s;
         sh_b_r  <= sh_b_nxt_s;
         cnt_r   <= cnt_nxt_s;
         busy_r  <= (state_nxt_s == TX_SHIFT);
      end
   end

endmodule

// File: tb/tb_serial_operand_tx.sv
// Randomized bench for serial_operand_tx against a transaction-level model
// (operand values, length and bit index) plus directed scenarios.
module tb_serial_operand_tx;
   import serial_pkg::*;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   ser_len_t   in_len;
   logic       out_en;
   logic       vld, a, b, last, busy;

   int n_vec = 0;
   int n_err = 0;

   // model: current transaction
   bit         m_active = 1'b0;
   logic [7:0] m_a = 8'd0, m_b = 8'd0;
   int         m_len = 0;
   int         m_idx = 0;
   // receiver capture of emitted bits
   logic [31:0] rx_a = 32'd0, rx_b = 32'd0;
   int          rx_n = 0;
   bit          last_acc;

   serial_operand_tx #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_len(in_len), .out_en(out_en),
      .vld(vld), .a(a), .b(b), .last(last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, check outputs, advance the model to the coming edge.
   task automatic step(input logic r, input logic v, input logic [7:0] da, input logic [7:0] db,
                       input int dl, input logic oe);
      bit e_vld, e_a, e_b, e_last, e_rdy;
      logic [31:0] mask;
      rst = r; in_valid = v; in_a = da; in_b = db; in_len = ser_len_t'(dl); out_en = oe;
      #1;
      e_vld  = !r && m_active && oe;
      e_a    = e_vld ? m_a[m_idx] : 1'b0;
      e_b    = e_vld ? m_b[m_idx] : 1'b0;
      e_last = e_vld && (m_idx == m_len);
      e_rdy  = !r && (!m_active || e_last);
      check_eq("vld", {31'd0, vld}, {31'd0, e_vld});
      check_eq("a", {31'd0, a}, {31'd0, e_a});
      check_eq("b", {31'd0, b}, {31'd0, e_b});
      check_eq("last", {31'd0, last}, {31'd0, e_last});
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      check_eq("busy", {31'd0, busy}, {31'd0, m_active});
      if (vld === 1'b1) begin
         rx_a = rx_a | ({31'd0, a} << rx_n);
         rx_b = rx_b | ({31'd0, b} << rx_n);
         rx_n++;
      end
      if (e_last && last === 1'b1) begin
         mask = (32'd1 << (m_len + 1)) - 32'd1;
         check_eq("txn_a", rx_a, {24'd0, m_a} & mask);
         check_eq("txn_b", rx_b, {24'd0, m_b} & mask);
         check_eq("txn_sum", (rx_a + rx_b) & mask, ({24'd0, m_a} + {24'd0, m_b}) & mask);
         check_eq("txn_nbits", rx_n, m_len + 1);
      end
      if (r || e_last) begin
         rx_a = 32'd0; rx_b = 32'd0; rx_n = 0;
      end
      last_acc = v && e_rdy;
      if (r) begin
         m_active = 1'b0;
      end else begin
         if (e_last) m_active = 1'b0;
         else if (e_vld) m_idx++;
         if (last_acc) begin
            m_active = 1'b1; m_a = da; m_b = db; m_len = dl; m_idx = 0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bit         s_pend;
      logic [7:0] s_a, s_b;
      int         s_len;
      rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_len = '0; out_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(1'b1, 1'b0, 8'd0, 8'd0, 0, 1'b1);
      step(1'b0, 1'b0, 8'd0, 8'd0, 0, 1'b0);

      // basic 0x0F + 0x01, 8 bits
      step(1'b0, 1'b1, 8'h0F, 8'h01, 7, 1'b1);
      repeat (9) step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);

      // back-to-back: second pair offered until accepted on the last bit
      step(1'b0, 1'b1, 8'hFF, 8'h01, 7, 1'b1);
      repeat (8) step(1'b0, 1'b1, 8'h03, 8'h05, 3, 1'b1);
      repeat (5) step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);

      // pacing with gaps, len 3
      step(1'b0, 1'b1, 8'h0A, 8'h05, 3, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 0, (i % 3) == 0);

      // single-bit transaction, idle with out_en low still accepts
      step(1'b0, 1'b1, 8'h01, 8'h01, 0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);

      // reset after 3 bits, then a clean restart
      step(1'b0, 1'b1, 8'hA5, 8'h3C, 7, 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      repeat (2) step(1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      step(1'b0, 1'b1, 8'h5A, 8'hC3, 7, 1'b1);
      repeat (9) step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);

      // truncation: upper nibble never sent
      step(1'b0, 1'b1, 8'hF0, 8'hF0, 3, 1'b1);
      repeat (5) step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);

      // random traffic with a well-behaved source
      s_pend = 1'b0; s_a = 8'd0; s_b = 8'd0; s_len = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!s_pend && $urandom_range(2, 0) != 0) begin
            s_pend = 1'b1;
            s_a = 8'($urandom);
            s_b = 8'($urandom);
            s_len = int'($urandom_range(7, 0));
         end
         step($urandom_range(99, 0) == 0, s_pend, s_a, s_b, s_len, $urandom_range(3, 0) != 0);
         if (last_acc) s_pend = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
